alarm_tone_detector: RTL and testbench
======================================

Name: alarm_tone_detector

Overview:
- Receive-side counterpart of the alarm sound generator.
- Samples an incoming alarm audio square wave on the system clock and measures its period.
- Classifies the signal as 500 Hz, 1 kHz, silent or invalid, and detects the 500 Hz / 1 kHz alternation that marks a genuine alarm.
- Used as an alarm-presence monitor and as a self-check on the audio path.

Parameters:
- P1K_MIN, 90: minimum rising-edge period, in CP cycles, accepted as 1 kHz.
- P1K_MAX, 110: maximum period accepted as 1 kHz.
- P500_MIN, 180: minimum period accepted as 500 Hz.
- P500_MAX, 220: maximum period accepted as 500 Hz.
- SILENT_CYC, 1000: cycles with no rising edge before the input is declared silent. Must exceed P500_MAX.
- N_CONFIRM, 3: consecutive identical classifications required before TONE changes.
- CW, 10: period counter width. Must satisfy 2^CW > SILENT_CYC.

Ports:
- CP  input  1  system clock; all logic on the rising edge.
- nCR  input  1  asynchronous active-low reset.
- CE  input  1  enable, active high. Low holds the block in its reset state, synchronously.
- AUDIO_IN  input  1  asynchronous audio square wave.
- TONE  output  2  confirmed tone: 00 silent, 01 500 Hz, 10 1 kHz, 11 invalid.
- SWITCH  output  1  one-cycle pulse when TONE changes directly between 01 and 10.
- ALARMING  output  1  high while a valid alternating alarm pattern is present.
- ERR  output  1  one-cycle pulse when TONE becomes 11.

Behaviour:
- Reset (nCR low, asynchronous) and CE low (synchronous) produce the same state:
  - TONE=00, SWITCH=0, ALARMING=0, ERR=0.
  - Synchronizer flops, period counter, confirm counter and candidate cleared.
  - FSM in IDLE; first-edge flag armed.
- Input conditioning:
  - AUDIO_IN passes through a 2-flop synchronizer.
  - A rising edge is detected as (sync=1, previous sync=0), giving a one-cycle internal pulse EDGE.
- Period counter:
  - Increments each cycle and saturates at SILENT_CYC.
  - On EDGE it reloads to 1, so the measured period equals the cycle distance between edges.
- Classification on EDGE:
  - If the first-edge flag is set: clear the flag, produce no classification.
  - Otherwise the count value before reload gives the class:
    - in [P1K_MIN, P1K_MAX] → 10
    - in [P500_MIN, P500_MAX] → 01
    - anything else → 11
  - Range bounds are inclusive.
- Confirmation:
  - If the class equals the candidate, the confirm counter increments, saturating at N_CONFIRM.
  - If it differs, the candidate takes the new class and the confirm counter is set to 1.
  - When the confirm counter reaches N_CONFIRM and the candidate differs from TONE, TONE takes the candidate on the next cycle.
  - Latency: 1 cycle after the EDGE carrying the N_CONFIRM-th match.
- Silence:
  - When the counter reaches SILENT_CYC, TONE goes to 00 on the next cycle.
  - The confirm counter and candidate clear and the first-edge flag re-arms.
  - Silence overrides confirmation and needs no N_CONFIRM.
- SWITCH: pulses in the same cycle TONE updates, only for 01→10 or 10→01.
- ERR: pulses in the cycle TONE updates to 11.
- Alternation FSM, evaluated on TONE updates:
  - IDLE: TONE becomes 01 or 10 → ARMED.
  - ARMED: a SWITCH → SEEN1.
  - SEEN1: a SWITCH → ALARM; ALARMING rises in the cycle after that SWITCH.
  - ALARM: further switches keep the state.
  - Any state: TONE becomes 00 or 11 → IDLE, ALARMING=0 in the same cycle TONE changes.
- Simultaneous events:
  - Silence threshold and EDGE in the same cycle: EDGE wins; the counter reloads and no silence is declared.
  - CE falling mid-measurement aborts everything; the next measurement starts with the first-edge flag set.
- No edges are ever dropped or double-counted while CE is high.

Test Plan:
- Reset mid-alarm: drive the ALARM state, pulse nCR low for 3 cycles → all outputs 0 immediately. After release, 3 valid 1 kHz periods give no TONE change: the first edge is consumed, so the 4th edge is needed.
- Steady 1 kHz (period 100):
  - TONE 00→10 one cycle after the 4th rising edge.
  - SWITCH=0, ERR=0, ALARMING=0.
- Alternation:
  - Stimulus: 10 periods of 100, then 5 of 200, then 10 of 100.
  - TONE sequence 10, 01, 10; SWITCH pulses twice.
  - ALARMING rises the cycle after the second SWITCH.
- Boundary periods:
  - 89 → 11 with ERR pulse; 90 and 110 → 10.
  - 179 → 11; 220 → 01; 221 → 11.
  - Each case uses 4 consecutive identical periods.
- Silence: after ALARM, hold AUDIO_IN low → TONE=00 and ALARMING=0 exactly SILENT_CYC cycles after the last counter reload; SWITCH stays 0.
- Glitch rejection: a TONE=10 stream interrupted by a single 150-cycle period → TONE stays 10 and ALARMING unaffected. Then 2 periods of 200 followed by 100 → TONE still 10, because the confirm counter restarted.

Source files
------------

// File: rtl/alarm_tone_detector.sv
// Alarm tone detector: measures the period of a synchronised audio square wave,
// classifies it as silent / 500 Hz / 1 kHz / invalid and tracks the alarm alternation.
module alarm_tone_detector #(
  parameter int P1K_MIN    = 90,
  parameter int P1K_MAX    = 110,
  parameter int P500_MIN   = 180,
  parameter int P500_MAX   = 220,
  parameter int SILENT_CYC = 1000,
  parameter int N_CONFIRM  = 3,
  parameter int CW         = 10
) (
  input  logic       i_cp,
  input  logic       i_ncr,
  input  logic       i_ce,
  input  logic       i_audio_in,
  output logic [1:0] o_tone,
  output logic       o_switch,
  output logic       o_alarming,
  output logic       o_err
);

  localparam int CFW = $clog2(N_CONFIRM + 1);

  localparam logic [1:0] TONE_SILENT = 2'b00;
  localparam logic [1:0] TONE_500    = 2'b01;
  localparam logic [1:0] TONE_1K     = 2'b10;
  localparam logic [1:0] TONE_INV    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SEEN1,
    S_ALARM
  } state_t;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_sync_prev;
  logic [CW-1:0]  r_cnt;
  logic           r_first;
  logic [1:0]     r_cand;
  logic [CFW-1:0] r_conf;
  logic [1:0]     r_tone;
  logic           r_switch;
  logic           r_err;
  state_t         r_state;

  logic           w_edge;
  logic           w_silence;
  logic           w_classify;
  logic           w_update;
  logic [1:0]     w_class;
  logic [1:0]     w_cand_next;
  logic [CFW-1:0] w_conf_next;
  logic [1:0]     w_tone_next;
  state_t         w_state_next;

  assign w_edge     = r_sync2 & ~r_sync_prev;
  assign w_silence  = (r_cnt == CW'(SILENT_CYC)) & ~w_edge;
  assign w_classify = w_edge & ~r_first;

  // r_cnt still holds the cycle distance since the previous edge while EDGE is high
  always_comb begin
    w_class = TONE_INV;
    if (r_cnt >= CW'(P1K_MIN) && r_cnt <= CW'(P1K_MAX)) begin
      w_class = TONE_1K;
    end else if (r_cnt >= CW'(P500_MIN) && r_cnt <= CW'(P500_MAX)) begin
      w_class = TONE_500;
    end
  end

  always_comb begin
    w_cand_next = r_cand;
    w_conf_next = r_conf;
    w_tone_next = r_tone;
    w_update    = 1'b0;
    if (w_silence) begin
      w_cand_next = TONE_SILENT;
      w_conf_next = '0;
      w_tone_next = TONE_SILENT;
      w_update    = (r_tone != TONE_SILENT);
    end else if (w_classify) begin
      if (w_class == r_cand) begin
        if (r_conf != CFW'(N_CONFIRM)) begin
          w_conf_next = r_conf + 1'b1;
        end
      end else begin
        w_cand_next = w_class;
        w_conf_next = CFW'(1);
      end
      if (w_conf_next == CFW'(N_CONFIRM) && w_cand_next != r_tone) begin
        w_tone_next = w_cand_next;
        w_update    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_cp or negedge i_ncr) begin
    if (!i_ncr) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_cand      <= TONE_SILENT;
      r_conf      <= '0;
      r_tone      <= TONE_SILENT;
      r_switch    <= 1'b0;
      r_err       <= 1'b0;
    end else if (!i_ce) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_cand      <= TONE_SILENT;
      r_conf      <= '0;
      r_tone      <= TONE_SILENT;
      r_switch    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync1     <= i_audio_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      if (w_edge) begin
        r_cnt <= CW'(1);
      end else if (r_cnt != CW'(SILENT_CYC)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_edge) begin
        r_first <= 1'b0;
      end else if (w_silence) begin
        r_first <= 1'b1;
      end
      r_cand   <= w_cand_next;
      r_conf   <= w_conf_next;
      r_tone   <= w_tone_next;
      r_switch <= w_update &&
                  ((r_tone == TONE_500 && w_tone_next == TONE_1K) ||
                   (r_tone == TONE_1K  && w_tone_next == TONE_500));
      r_err    <= w_update && (w_tone_next == TONE_INV);
    end
  end

  always_ff @(posedge i_cp or negedge i_ncr) begin
    if (!i_ncr) begin
      r_state <= S_IDLE;
    end else if (!i_ce) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leaving a valid tone drops the FSM together with the TONE update; switches
  // are taken from the registered pulse, so ALARMING follows SWITCH by a cycle.
  always_comb begin
    w_state_next = r_state;
    if (w_update && (w_tone_next == TONE_SILENT || w_tone_next == TONE_INV)) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_tone == TONE_500 || r_tone == TONE_1K) w_state_next = S_ARMED;
        S_ARMED: if (r_switch) w_state_next = S_SEEN1;
        S_SEEN1: if (r_switch) w_state_next = S_ALARM;
        default: w_state_next = r_state;
      endcase
    end
  end

  assign o_tone     = r_tone;
  assign o_switch   = r_switch;
  assign o_err      = r_err;
  assign o_alarming = (r_state == S_ALARM);

endmodule

// File: tb/tb_alarm_tone_detector.sv
// Directed bench for alarm_tone_detector: drives square waves of chosen periods and
// checks TONE/SWITCH/ERR/ALARMING values and their cycle timing.
module tb_alarm_tone_detector;

  logic       clk = 1'b0;
  logic       nCr;
  logic       ce;
  logic       audio;
  logic [1:0] tone;
  logic       sw;
  logic       alarming;
  logic       err;

  int assertCount = 0;
  int failCount   = 0;
  int posCount    = 0;
  int lastRise    = 0;

  int lastToneChangeCyc = 0;
  int lastSwitchCyc     = 0;
  int lastErrCyc        = 0;
  int lastAlarmRiseCyc  = 0;
  int lastAlarmFallCyc  = 0;
  int switchCount       = 0;
  int errCount          = 0;
  logic [1:0] prevTone  = 2'b00;
  logic       prevAlarm = 1'b0;

  int bnd     [6] = '{89, 90, 110, 179, 220, 221};
  int bndTone [6] = '{3, 2, 2, 3, 1, 3};
  int bndChg  [6] = '{1, 1, 0, 1, 1, 1};

  alarm_tone_detector dut (
    .i_cp       (clk),
    .i_ncr      (nCr),
    .i_ce       (ce),
    .i_audio_in (audio),
    .o_tone     (tone),
    .o_switch   (sw),
    .o_alarming (alarming),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) posCount <= posCount + 1;

  // Outputs are observed on the falling edge; posCount then names the rising edge just seen
  always @(negedge clk) begin
    if (tone !== prevTone) lastToneChangeCyc = posCount;
    if (alarming && !prevAlarm) lastAlarmRiseCyc = posCount;
    if (!alarming && prevAlarm) lastAlarmFallCyc = posCount;
    if (sw) begin
      switchCount++;
      lastSwitchCyc = posCount;
    end
    if (err) begin
      errCount++;
      lastErrCyc = posCount;
    end
    prevTone  = tone;
    prevAlarm = alarming;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full period starting with a rising edge; the DUT sees it on the next clock
  // and a resulting TONE change is visible three clocks after lastRise.
  task automatic applyStimulus(input int period);
    audio    = 1'b1;
    lastRise = posCount;
    waitCycles(period / 2);
    audio = 1'b0;
    waitCycles(period - period / 2);
  endtask

  initial begin
    int sw0;
    int er0;
    int r200;
    int r100;
    int toneCyc;
    int silRise;
    int expCyc;

    nCr   = 1'b0;
    ce    = 1'b1;
    audio = 1'b0;
    waitCycles(3);
    checkOutput("reset_tone", 32'(tone), 0);
    checkOutput("reset_switch", 32'(sw), 0);
    checkOutput("reset_alarming", 32'(alarming), 0);
    checkOutput("reset_err", 32'(err), 0);
    nCr = 1'b1;
    waitCycles(2);

    sw0 = switchCount;
    er0 = errCount;
    repeat (3) applyStimulus(100);
    checkOutput("1k_tone_after_3_edges", 32'(tone), 0);
    applyStimulus(100);
    checkOutput("1k_tone", 32'(tone), 2);
    checkOutput("1k_latency", lastToneChangeCyc, lastRise + 3);
    checkOutput("1k_switch_count", switchCount - sw0, 0);
    checkOutput("1k_err_count", errCount - er0, 0);
    checkOutput("1k_alarming", 32'(alarming), 0);

    repeat (6) applyStimulus(100);
    r200 = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(200);
      if (k == 3) r200 = lastRise;
    end
    checkOutput("alt_tone_500", 32'(tone), 1);
    checkOutput("alt_switch1_cycle", lastSwitchCyc, r200 + 3);
    checkOutput("alt_switch1_count", switchCount - sw0, 1);
    checkOutput("alt_alarming_early", 32'(alarming), 0);
    r100 = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(100);
      if (k == 3) r100 = lastRise;
    end
    checkOutput("alt_tone_1k", 32'(tone), 2);
    checkOutput("alt_switch2_cycle", lastSwitchCyc, r100 + 3);
    checkOutput("alt_switch2_count", switchCount - sw0, 2);
    checkOutput("alt_alarm_rise", lastAlarmRiseCyc, r100 + 4);
    checkOutput("alt_alarming", 32'(alarming), 1);
    checkOutput("alt_err_count", errCount - er0, 0);

    toneCyc = lastToneChangeCyc;
    applyStimulus(150);
    repeat (4) applyStimulus(100);
    applyStimulus(200);
    applyStimulus(200);
    applyStimulus(100);
    applyStimulus(100);
    checkOutput("glitch_tone", 32'(tone), 2);
    checkOutput("glitch_no_change", lastToneChangeCyc, toneCyc);
    checkOutput("glitch_alarming", 32'(alarming), 1);
    checkOutput("glitch_err_count", errCount - er0, 0);
    checkOutput("glitch_switch_count", switchCount - sw0, 2);

    silRise = lastRise;
    waitCycles(910);
    checkOutput("silence_tone", 32'(tone), 0);
    checkOutput("silence_tone_cycle", lastToneChangeCyc, silRise + 1003);
    checkOutput("silence_alarm_fall", lastAlarmFallCyc, silRise + 1003);
    checkOutput("silence_alarming", 32'(alarming), 0);
    checkOutput("silence_switch_count", switchCount - sw0, 2);

    sw0    = switchCount;
    er0    = errCount;
    expCyc = lastToneChangeCyc;
    for (int i = 0; i < 6; i++) begin
      repeat (4) applyStimulus(bnd[i]);
      if (bndChg[i] != 0) expCyc = lastRise + 3;
      checkOutput($sformatf("bound_%0d_tone", bnd[i]), 32'(tone), bndTone[i]);
      checkOutput($sformatf("bound_%0d_cycle", bnd[i]), lastToneChangeCyc, expCyc);
    end
    checkOutput("bound_err_count", errCount - er0, 3);
    checkOutput("bound_err_cycle", lastErrCyc, lastRise + 3);
    checkOutput("bound_switch_count", switchCount - sw0, 0);
    checkOutput("bound_alarming", 32'(alarming), 0);

    repeat (4) applyStimulus(100);
    repeat (4) applyStimulus(200);
    repeat (4) applyStimulus(100);
    checkOutput("prereset_alarming", 32'(alarming), 1);
    nCr = 1'b0;
    #1;
    checkOutput("midreset_tone", 32'(tone), 0);
    checkOutput("midreset_alarming", 32'(alarming), 0);
    checkOutput("midreset_switch", 32'(sw), 0);
    checkOutput("midreset_err", 32'(err), 0);
    waitCycles(3);
    nCr = 1'b1;
    repeat (3) applyStimulus(100);
    checkOutput("postreset_tone_3_edges", 32'(tone), 0);
    applyStimulus(100);
    checkOutput("postreset_tone", 32'(tone), 2);
    checkOutput("postreset_latency", lastToneChangeCyc, lastRise + 3);

    ce = 1'b0;
    waitCycles(1);
    checkOutput("ce_low_tone", 32'(tone), 0);
    ce = 1'b1;
    repeat (3) applyStimulus(100);
    checkOutput("ce_restart_tone", 32'(tone), 0);
    applyStimulus(100);
    checkOutput("ce_restart_tone_1k", 32'(tone), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
